// File: rtl/shift_normalizer.sv
// shift_normalizer: iterative leading-bit normalizer.
// Finds the left shift that sets the MSB (logical mode) or makes the top two
// bits differ (arithmetic mode), one binary-search stage per clock.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready are
// both high. The producer holds its payload while valid is high and ready is
// low. in_ready decodes state only, so it never depends combinationally on
// in_valid or out_ready. result/shift/zero hold from out_valid rising until the
// output transfer, and keep their value afterwards until the next result.
module shift_normalizer #(
   parameter int WIDTH       = 8,
   parameter int SHIFT_WIDTH = $clog2(WIDTH)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [WIDTH-1:0]       src,
   input  logic                   norm_arith,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [WIDTH-1:0]       result,
   output logic [SHIFT_WIDTH-1:0] shift,
   output logic                   zero,
   output logic [1:0]             state_dbg
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                 state;
   logic [WIDTH-1:0]       work;
   logic                   mode;
   logic [SHIFT_WIDTH-1:0] count;
   logic [SHIFT_WIDTH-1:0] k;

   logic                   src_zero;
   logic [SHIFT_WIDTH-1:0] stage_pass;
   logic [WIDTH-1:0]       stage_work [SHIFT_WIDTH];
   logic [WIDTH-1:0]       next_work;
   logic [SHIFT_WIDTH-1:0] next_count;

   assign in_ready  = (state == IDLE) && rst_n;
   assign out_valid = (state == DONE);
   assign state_dbg = state;

   // An operand with no significant bits skips the search entirely.
   assign src_zero = norm_arith ? ((src == '0) || (src == '1)) : (src == '0);

   // One test/shift pair per stage; stage g checks whether a 2^g shift is safe.
   for (genvar g = 0; g < SHIFT_WIDTH; g++) begin : g_stage
      localparam int SPAN = 1 << g;
      logic [SPAN-1:0] top_l;
      logic [SPAN:0]   top_a;
      assign top_l         = work[WIDTH-1 -: SPAN];
      assign top_a         = work[WIDTH-1 -: SPAN+1];
      assign stage_pass[g] = mode ? ((top_a == '0) || (top_a == '1)) : (top_l == '0);
      assign stage_work[g] = {work[WIDTH-1-SPAN:0], {SPAN{1'b0}}};
   end

   // Apply the current stage k to the work register and the shift count.
   always_comb begin
      next_work  = work;
      next_count = count;
      if (stage_pass[k]) begin
         next_work     = stage_work[k];
         next_count[k] = 1'b1;
      end
   end

   // Control FSM with registered datapath and outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= IDLE;
         work   <= '0;
         mode   <= 1'b0;
         count  <= '0;
         k      <= '0;
         result <= '0;
         shift  <= '0;
         zero   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  if (src_zero) begin
                     result <= src;
                     shift  <= '0;
                     zero   <= 1'b1;
                     state  <= DONE;
                  end else begin
                     work  <= src;
                     mode  <= norm_arith;
                     count <= '0;
                     k     <= SHIFT_WIDTH'(SHIFT_WIDTH - 1);
                     state <= BUSY;
                  end
               end
            end
            BUSY: begin
               work  <= next_work;
               count <= next_count;
               k     <= k - 1'b1;
               if (k == '0) begin
                  result <= next_work;
                  shift  <= next_count;
                  zero   <= 1'b0;
                  state  <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_shift_normalizer.sv
// tb_shift_normalizer: directed and random checks for shift_normalizer (WIDTH=8).
module tb_shift_normalizer;
   localparam int W  = 8;
   localparam int SW = 3;

   logic          clk;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  src;
   logic          norm_arith;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  result;
   logic [SW-1:0] shift;
   logic          zero;
   logic [1:0]    state_dbg;

   int n_checks = 0;
   int n_pass   = 0;

   // {zero, shift, result}
   logic [W+SW:0] exp_q[$];

   shift_normalizer #(.WIDTH(W), .SHIFT_WIDTH(SW)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .src(src), .norm_arith(norm_arith), .out_valid(out_valid),
      .out_ready(out_ready), .result(result), .shift(shift), .zero(zero),
      .state_dbg(state_dbg)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want)
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
      else
         n_pass++;
   endtask

   // advance one clock; sample and drive 1ns after the edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // reference: count leading bits equal to the sign (or zero) bit
   function automatic logic [W+SW:0] ref_norm(input logic [W-1:0] s, input logic m);
      int   lead;
      int   sh;
      logic lead_bit;
      lead_bit = m ? s[W-1] : 1'b0;
      lead = 0;
      for (int i = W - 1; i >= 0; i--) begin
         if (s[i] != lead_bit) break;
         lead++;
      end
      if (lead == W) return {1'b1, SW'(0), s};
      sh = m ? lead - 1 : lead;
      return {1'b0, SW'(sh), W'(s << sh)};
   endfunction

   // drive one operand, expect result after exp_lat edges counting the accept edge
   task automatic run_directed(input string tag, input logic [W-1:0] s, input logic m,
                               input logic [W-1:0] exp_r, input logic [SW-1:0] exp_s,
                               input logic exp_z, input int exp_lat);
      int lat;
      check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      in_valid   = 1'b1;
      src        = s;
      norm_arith = m;
      out_ready  = 1'b1;
      step();
      in_valid   = 1'b0;
      src        = ~s;
      norm_arith = ~m;
      lat = 1;
      while (!out_valid && lat < 20) begin
         step();
         lat++;
      end
      check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
      check({tag, "_result"}, 32'(result), 32'(exp_r));
      check({tag, "_shift"}, 32'(shift), 32'(exp_s));
      check({tag, "_zero"}, 32'(zero), 32'(exp_z));
      step();
      check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
      check({tag, "_ready_back"}, 32'(in_ready), 32'd1);
   endtask

   // random operand through the expected queue with random output stalls
   task automatic run_random(input logic [W-1:0] s, input logic m, input int stall);
      int            lat;
      logic [W+SW:0] e;
      exp_q.push_back(ref_norm(s, m));
      in_valid   = 1'b1;
      src        = s;
      norm_arith = m;
      out_ready  = 1'b0;
      step();
      in_valid = 1'b0;
      src      = W'($urandom_range(0, 255));
      lat = 1;
      while (!out_valid && lat < 20) begin
         step();
         lat++;
      end
      if (!out_valid) begin
         check("rand_timeout", 32'(out_valid), 32'd1);
      end
      repeat (stall) step();
      e = exp_q.pop_front();
      check("rand_result", 32'(result), 32'(e[W-1:0]));
      check("rand_shift", 32'(shift), 32'(e[W+SW-1:W]));
      check("rand_zero", 32'(zero), 32'(e[W+SW]));
      check("rand_shl", 32'(result), 32'(W'(s << shift)));
      if (!e[W+SW]) begin
         if (m) check("rand_arith_norm", 32'(result[W-1] ^ result[W-2]), 32'd1);
         else   check("rand_logic_norm", 32'(result[W-1]), 32'd1);
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   initial begin
      int   lat;
      logic seen_valid;

      rst_n      = 1'b0;
      in_valid   = 1'b0;
      src        = '0;
      norm_arith = 1'b0;
      out_ready  = 1'b0;
      repeat (3) step();
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_result", 32'(result), 32'd0);
      check("rst_shift", 32'(shift), 32'd0);
      check("rst_zero", 32'(zero), 32'd0);
      check("rst_state", 32'(state_dbg), 32'd0);
      rst_n = 1'b1;
      step();
      check("rel_in_ready", 32'(in_ready), 32'd1);

      // logical normalization
      run_directed("log_13", 8'h13, 1'b0, 8'h98, 3'd3, 1'b0, 4);
      run_directed("log_01", 8'h01, 1'b0, 8'h80, 3'd7, 1'b0, 4);
      run_directed("log_80", 8'h80, 1'b0, 8'h80, 3'd0, 1'b0, 4);
      // arithmetic normalization
      run_directed("ari_f3", 8'hF3, 1'b1, 8'h98, 3'd3, 1'b0, 4);
      run_directed("ari_0c", 8'h0C, 1'b1, 8'h60, 3'd3, 1'b0, 4);
      run_directed("ari_40", 8'h40, 1'b1, 8'h40, 3'd0, 1'b0, 4);
      run_directed("ari_01", 8'h01, 1'b1, 8'h40, 3'd6, 1'b0, 4);
      run_directed("ari_fe", 8'hFE, 1'b1, 8'h80, 3'd6, 1'b0, 4);
      // zero cases
      run_directed("zlog_00", 8'h00, 1'b0, 8'h00, 3'd0, 1'b1, 1);
      run_directed("zari_ff", 8'hFF, 1'b1, 8'hFF, 3'd0, 1'b1, 1);
      run_directed("zari_00", 8'h00, 1'b1, 8'h00, 3'd0, 1'b1, 1);
      run_directed("log_ff", 8'hFF, 1'b0, 8'hFF, 3'd0, 1'b0, 4);

      // backpressure with in_valid held and src toggling
      in_valid   = 1'b1;
      src        = 8'h13;
      norm_arith = 1'b0;
      out_ready  = 1'b0;
      step();
      lat = 1;
      while (!out_valid && lat < 20) begin
         src = ~src;
         step();
         lat++;
      end
      check("bp_latency", 32'(lat), 32'd4);
      for (int i = 0; i < 6; i++) begin
         src        = W'($urandom_range(0, 255));
         norm_arith = ~norm_arith;
         step();
         check("bp_valid", 32'(out_valid), 32'd1);
         check("bp_in_ready", 32'(in_ready), 32'd0);
         check("bp_result", 32'(result), 32'h98);
         check("bp_shift", 32'(shift), 32'd3);
         check("bp_zero", 32'(zero), 32'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();
      check("bp_release_valid", 32'(out_valid), 32'd0);
      check("bp_release_ready", 32'(in_ready), 32'd1);
      step();
      check("bp_no_queue", 32'(out_valid), 32'd0);
      check("bp_hold_idle", 32'(result), 32'h98);

      // reset in the middle of BUSY
      in_valid   = 1'b1;
      src        = 8'h13;
      norm_arith = 1'b0;
      step();
      in_valid = 1'b0;
      step();
      rst_n = 1'b0;
      step();
      check("mid_rst_valid", 32'(out_valid), 32'd0);
      check("mid_rst_ready", 32'(in_ready), 32'd0);
      check("mid_rst_result", 32'(result), 32'd0);
      check("mid_rst_shift", 32'(shift), 32'd0);
      check("mid_rst_zero", 32'(zero), 32'd0);
      rst_n = 1'b1;
      seen_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (out_valid) seen_valid = 1'b1;
      end
      check("mid_rst_discard", 32'(seen_valid), 32'd0);
      run_directed("post_rst_01", 8'h01, 1'b0, 8'h80, 3'd7, 1'b0, 4);

      // random operands in both modes
      for (int i = 0; i < 1000; i++) begin
         run_random(W'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 2));
      end
      check("exp_q_empty", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
